// File: rtl/signed_minmax_pkg.sv
// Shared types and defaults for the signed min/max frame sequencer.
//   minmax_state_t    : sequencer FSM states
//   DefaultSize       : default sample width (two's complement)
//   DefaultCountWidth : default width of sample counter and index outputs
package signed_minmax_pkg;

    localparam int unsigned DefaultSize       = 8;
    localparam int unsigned DefaultCountWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StCmpMax,
        StCmpMin,
        StDone
    } minmax_state_t;

endpackage

// File: rtl/signed_comparator.sv
// Combinational two's-complement comparator.
//   a, b         : signed operands, SIZE bits
//   is_a_greater : a > b (signed)
//   equal        : a == b
module signed_comparator #(
    parameter int unsigned SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            is_a_greater,
    output logic            equal
);

    assign is_a_greater = $signed(a) > $signed(b);
    assign equal        = (a == b);

endmodule

// File: rtl/signed_minmax_seq.sv
// Frame sequencer reporting the running signed max/min (and first-occurrence index) of a
// sample stream, time-sharing one comparator across a max compare and a min compare.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : opens a frame (IDLE only)
//   in_valid/in_ready  : sample handshake; in_data sample, in_last marks final sample
//   out_valid/out_ready: result handshake; results held in DONE
//   max_val/min_val    : frame extremes; max_idx/min_idx their first indices
//   count              : samples accepted (saturating); busy: FSM not idle
module signed_minmax_seq
    import signed_minmax_pkg::*;
#(
    parameter int unsigned SIZE        = DefaultSize,
    parameter int unsigned COUNT_WIDTH = DefaultCountWidth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZE-1:0]        in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE-1:0]        max_val,
    output logic [SIZE-1:0]        min_val,
    output logic [COUNT_WIDTH-1:0] max_idx,
    output logic [COUNT_WIDTH-1:0] min_idx,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   busy
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

    minmax_state_t          state_q, state_d;
    logic [SIZE-1:0]        hold_q, hold_d;
    logic                   hold_last_q, hold_last_d;
    logic [SIZE-1:0]        max_val_q, max_val_d;
    logic [SIZE-1:0]        min_val_q, min_val_d;
    logic [COUNT_WIDTH-1:0] max_idx_q, max_idx_d;
    logic [COUNT_WIDTH-1:0] min_idx_q, min_idx_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [SIZE-1:0] cmp_a, cmp_b;
    logic            cmp_gt;
    logic            unused_equal;

    signed_comparator #(
        .SIZE(SIZE)
    ) cmp (
        .a           (cmp_a),
        .b           (cmp_b),
        .is_a_greater(cmp_gt),
        .equal       (unused_equal)
    );

    // Operand order flips between phases so that "a > b" means "hold is a new extreme"
    // in both; strict compare keeps the earliest index on ties.
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        unique case (state_q)
            StCmpMax: begin
                cmp_a = hold_q;
                cmp_b = max_val_q;
            end
            StCmpMin: begin
                cmp_a = min_val_q;
                cmp_b = hold_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_last_d = hold_last_q;
        max_val_d   = max_val_q;
        min_val_d   = min_val_q;
        max_idx_d   = max_idx_q;
        min_idx_d   = min_idx_q;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    max_val_d = '0;
                    min_val_d = '0;
                    max_idx_d = '0;
                    min_idx_d = '0;
                    count_d   = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (in_valid) begin
                    if (count_q == '0) begin
                        max_val_d = in_data;
                        min_val_d = in_data;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        count_d   = COUNT_WIDTH'(1);
                        state_d   = in_last ? StDone : StWait;
                    end else begin
                        hold_d      = in_data;
                        hold_last_d = in_last;
                        state_d     = StCmpMax;
                    end
                end
            end
            StCmpMax: begin
                if (cmp_gt) begin
                    max_val_d = hold_q;
                    max_idx_d = count_q;
                end
                state_d = StCmpMin;
            end
            StCmpMin: begin
                if (cmp_gt) begin
                    min_val_d = hold_q;
                    min_idx_d = count_q;
                end
                // Saturate so a long frame never wraps back to "first sample".
                if (count_q != CountMax) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                end
                state_d = hold_last_q ? StDone : StWait;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            max_val_q   <= '0;
            min_val_q   <= '0;
            max_idx_q   <= '0;
            min_idx_q   <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            max_val_q   <= max_val_d;
            min_val_q   <= min_val_d;
            max_idx_q   <= max_idx_d;
            min_idx_q   <= min_idx_d;
            count_q     <= count_d;
        end
    end

    assign in_ready  = (state_q == StWait);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign max_val   = max_val_q;
    assign min_val   = min_val_q;
    assign max_idx   = max_idx_q;
    assign min_idx   = min_idx_q;
    assign count     = count_q;

endmodule
